// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//
// Unified program/data memory plus the fetch address register (AR) and the
// temp/data address register (TEMP_AR). This is the responder side of the
// control unit's memory interface.
//
// After reset the block sits in S_LOAD and accepts a program image from the
// host over a valid/ready handshake. The beat marked Host_last moves it to
// S_RUN, which raises Run_enable. From then on the control-unit strobes drive
// the address registers and run-time writes. Reads are combinational from the
// registered addresses, so an address loaded on one edge gives valid data in
// the following cycle.
//
// Optional feature macro: MEM_WRITE_PROTECT_EN
//   When defined, a run-time write to an address below PROTECT_BASE is
//   dropped and sets a sticky Protect_fault. Host loads are never protected.
//   When undefined, all writes are honoured and Protect_fault is tied to 0.
//
// Parameters:
//   DATA_W       memory word and bus width (must be >= ADDR_W)
//   ADDR_W       address width; depth = 2**ADDR_W
//   PROTECT_BASE lowest writable run-time address (protect feature only)
//
// Ports:
//   CLK                  system clock, rising edge
//   RESET                asynchronous, active-high reset
//   BUS_1                datapath bus: AR load source and write data
//   Load_ADDRESS_R       AR <= BUS_1
//   Load_TEMP_ADD_R      TEMP_AR <= Mem_out (pre-edge read)
//   INC_AR / INC_TEMP_AR increment the matching register (wraps)
//   Select_MEMORY_DEMUX  read address select: 0 = AR, 1 = TEMP_AR
//   Write_MEMORY         mem[TEMP_AR] <= BUS_1
//   Host_valid/addr/data/last, Host_ready   program-load handshake
//   Run_enable           program loaded; control unit may run
//   Mem_out              combinational read data
//   AR_value, TEMP_AR_value   debug views of the address registers
//   Protect_fault        sticky illegal-write flag
// -----------------------------------------------------------------------------
module memory_responder #(
   parameter int                DATA_W       = 8,
   parameter int                ADDR_W       = 8,
   parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'h40
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] BUS_1,
   input  logic              Load_ADDRESS_R,
   input  logic              Load_TEMP_ADD_R,
   input  logic              INC_AR,
   input  logic              INC_TEMP_AR,
   input  logic              Select_MEMORY_DEMUX,
   input  logic              Write_MEMORY,
   input  logic              Host_valid,
   input  logic [ADDR_W-1:0] Host_addr,
   input  logic [DATA_W-1:0] Host_data,
   input  logic              Host_last,
   output logic              Host_ready,
   output logic              Run_enable,
   output logic [DATA_W-1:0] Mem_out,
   output logic [ADDR_W-1:0] AR_value,
   output logic [ADDR_W-1:0] TEMP_AR_value,
   output logic              Protect_fault
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   ar_reg;
   logic [ADDR_W-1:0]   temp_ar_reg;
   logic                host_ready_reg;
   logic                run_enable_reg;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   read_addr;
   logic [DATA_W-1:0]   read_data;
   logic                host_accept;
   logic                run_active;
   logic                write_allowed;
   logic                mem_write;

   // Host_ready is only ever 1 in S_LOAD, so it alone qualifies a beat.
   assign host_accept = Host_valid && host_ready_reg;
   assign run_active  = (state_reg == S_RUN);

`ifdef MEM_WRITE_PROTECT_EN
   logic protect_fault_reg;
   assign write_allowed = (temp_ar_reg >= PROTECT_BASE);
   assign Protect_fault = protect_fault_reg;
`else
   // The base address only matters when protection is built in.
   logic unused_protect_base;
   assign unused_protect_base = ^PROTECT_BASE;
   assign write_allowed = 1'b1;
   assign Protect_fault = 1'b0;
`endif

   // Run-time write always targets TEMP_AR as it stands before the edge.
   assign mem_write = run_active && Write_MEMORY && write_allowed;

   // Combinational read from the registered addresses.
   assign read_addr = Select_MEMORY_DEMUX ? temp_ar_reg : ar_reg;
   assign read_data = mem[read_addr];
   assign Mem_out   = read_data;

   // Memory array: not reset, so a partial image survives a reset. Host
   // beats and run-time writes are mutually exclusive by state.
   always_ff @(posedge CLK) begin
      if (host_accept) begin
         mem[Host_addr] <= Host_data;
      end else if (mem_write) begin
         mem[temp_ar_reg] <= BUS_1;
      end
   end

   // Control FSM with address registers and registered handshake outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg      <= S_LOAD;
         ar_reg         <= '0;
         temp_ar_reg    <= '0;
         host_ready_reg <= 1'b0;
         run_enable_reg <= 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
         protect_fault_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_LOAD: begin
               // Control-unit strobes are ignored while loading.
               if (host_accept && Host_last) begin
                  state_reg      <= S_RUN;
                  host_ready_reg <= 1'b0;
                  run_enable_reg <= 1'b1;
               end else begin
                  host_ready_reg <= 1'b1;
               end
            end
            S_RUN: begin
               if (Load_ADDRESS_R) begin
                  ar_reg <= BUS_1[ADDR_W-1:0];
               end else if (INC_AR) begin
                  ar_reg <= ar_reg + ADDR_ONE;
               end

               // The pointer load uses the pre-edge read, whichever register
               // the demux currently selects.
               if (Load_TEMP_ADD_R) begin
                  temp_ar_reg <= read_data[ADDR_W-1:0];
               end else if (INC_TEMP_AR) begin
                  temp_ar_reg <= temp_ar_reg + ADDR_ONE;
               end
`ifdef MEM_WRITE_PROTECT_EN
               if (Write_MEMORY && !write_allowed) begin
                  protect_fault_reg <= 1'b1;
               end
`endif
            end
            default: begin
               state_reg <= S_LOAD;
            end
         endcase
      end
   end

   assign Host_ready    = host_ready_reg;
   assign Run_enable    = run_enable_reg;
   assign AR_value      = ar_reg;
   assign TEMP_AR_value = temp_ar_reg;

endmodule

// File: tb/tb_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_responder
//
// Self-checking bench for memory_responder. A behavioural model (plain arrays
// and arithmetic) tracks memory contents, AR, TEMP_AR, the load/run phase and
// the fault flag. Host loads, directed run-time scenarios and a randomized run
// phase are checked against it, followed by a mid-run reset with read-back of
// the retained memory.
// -----------------------------------------------------------------------------
module tb_memory_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bus;
   logic       ld_ar, ld_tar, inc_ar, inc_tar, sel, wr;
   logic       h_valid, h_last;
   logic [7:0] h_addr, h_data;
   logic       h_ready, run_en, fault;
   logic [7:0] mem_out, ar_val, tar_val;

   always #5 clk = ~clk;

`ifdef MEM_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   memory_responder #(
      .DATA_W(8),
      .ADDR_W(8),
      .PROTECT_BASE(8'h40)
   ) dut (
      .CLK                 (clk),
      .RESET               (rst),
      .BUS_1               (bus),
      .Load_ADDRESS_R      (ld_ar),
      .Load_TEMP_ADD_R     (ld_tar),
      .INC_AR              (inc_ar),
      .INC_TEMP_AR         (inc_tar),
      .Select_MEMORY_DEMUX (sel),
      .Write_MEMORY        (wr),
      .Host_valid          (h_valid),
      .Host_addr           (h_addr),
      .Host_data           (h_data),
      .Host_last           (h_last),
      .Host_ready          (h_ready),
      .Run_enable          (run_en),
      .Mem_out             (mem_out),
      .AR_value            (ar_val),
      .TEMP_AR_value       (tar_val),
      .Protect_fault       (fault)
   );

   // ---------------- reference model ----------------
   logic [7:0] m_mem [256];
   bit         m_known [256];
   logic [7:0] m_ar, m_tar;
   bit         m_run, m_ready, m_fault;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_ar    = 8'h00;
      m_tar   = 8'h00;
      m_run   = 1'b0;
      m_ready = 1'b0;
      m_fault = 1'b0;
   endtask

   // One clock edge of the model, using the inputs as they stand.
   task automatic model_edge();
      logic [7:0] rd;
      if (rst) begin
         m_reset();
      end else if (!m_run) begin
         if (h_valid && m_ready) begin
            m_mem[h_addr]   = h_data;
            m_known[h_addr] = 1'b1;
            if (h_last) begin
               m_run   = 1'b1;
               m_ready = 1'b0;
            end else begin
               m_ready = 1'b1;
            end
         end else begin
            m_ready = 1'b1;
         end
      end else begin
         rd = sel ? m_mem[m_tar] : m_mem[m_ar];
         if (wr) begin
            if (PROT && (m_tar < 8'h40)) begin
               m_fault = 1'b1;
            end else begin
               m_mem[m_tar]   = bus;
               m_known[m_tar] = 1'b1;
            end
         end
         if (ld_ar)        m_ar = bus;
         else if (inc_ar)  m_ar = 8'((int'(m_ar) + 1) % 256);
         if (ld_tar)       m_tar = rd;
         else if (inc_tar) m_tar = 8'((int'(m_tar) + 1) % 256);
      end
   endtask

   task automatic check_regs();
      check_value("ar", ar_val, m_ar);
      check_value("temp_ar", tar_val, m_tar);
      check_value("host_ready", h_ready, m_ready);
      check_value("run_enable", run_en, m_run);
      check_value("protect_fault", fault, m_fault);
   endtask

   // Check the read path mid-cycle, advance one edge, then check registers.
   task automatic tick();
      logic [7:0] a;
      @(negedge clk);
      a = sel ? m_tar : m_ar;
      if (m_known[a]) check_value("mem_out", mem_out, m_mem[a]);
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic idle();
      bus = 8'h00; ld_ar = 0; ld_tar = 0; inc_ar = 0; inc_tar = 0;
      sel = 0; wr = 0; h_valid = 0; h_last = 0; h_addr = 8'h00; h_data = 8'h00;
   endtask

   task automatic rand_strobes();
      bus     = 8'($urandom);
      ld_ar   = ($urandom_range(0, 3) == 0);
      ld_tar  = ($urandom_range(0, 3) == 0);
      inc_ar  = ($urandom_range(0, 2) == 0);
      inc_tar = ($urandom_range(0, 2) == 0);
      sel     = 1'($urandom);
      wr      = ($urandom_range(0, 3) == 0);
   endtask

   // Host beat with random idle gaps and random (ignored) run strobes.
   task automatic host_beat(input logic [7:0] a, input logic [7:0] d, input logic last);
      repeat ($urandom_range(0, 1)) begin
         rand_strobes();
         h_valid = 1'b0;
         tick();
      end
      rand_strobes();
      h_valid = 1'b1; h_addr = a; h_data = d; h_last = last;
      $display("host beat addr=%02h data=%02h last=%0b", a, d, last);
      tick();
      idle();
   endtask

   task automatic load_ar(input logic [7:0] v);
      idle(); bus = v; ld_ar = 1'b1; tick(); idle();
   endtask

   task automatic load_tar_from_ar();
      idle(); ld_tar = 1'b1; sel = 1'b0; tick(); idle();
   endtask

   logic [7:0] d, old, a;

   initial begin
      for (int i = 0; i < 256; i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = 8'h00;
      end
      idle();
      m_reset();
      rst = 1'b1;
      #1;
      check_regs();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_value("ready_before_first_clock", h_ready, 1'b0);
      tick();
      check_value("ready_first_clock", h_ready, 1'b1);

      // ---------------- program load ----------------
      for (int i = 255; i >= 3; i--) begin
         case (i)
            3:       d = 8'h80;
            4:       d = 8'hFF;
            6:       d = 8'h10;
            default: d = 8'($urandom);
         endcase
         host_beat(8'(i), d, 1'b0);
      end
      host_beat(8'h00, 8'h00, 1'b0);
      host_beat(8'h01, 8'h05, 1'b0);
      host_beat(8'h02, 8'h09, 1'b1);
      check_value("run_after_last", run_en, 1'b1);
      check_value("ready_after_last", h_ready, 1'b0);
      // Host beat in run must be ignored.
      h_valid = 1'b1; h_addr = 8'h05; h_data = 8'hEE; h_last = 1'b1;
      tick();
      idle();

      // ---------------- fetch read ----------------
      load_ar(8'h01);
      #1 check_value("fetch_read", mem_out, 8'h05);
      inc_ar = 1'b1; tick(); idle();
      #1 check_value("fetch_inc", mem_out, 8'h09);

      // ---------------- indirect address ----------------
      load_ar(8'h01);
      load_tar_from_ar();
      check_value("indirect_tar", tar_val, 8'h05);
      sel = 1'b1;
      #1 check_value("indirect_read", mem_out, m_mem[5]);
      idle();

      // ---------------- write + increment ----------------
      load_ar(8'h03);
      load_tar_from_ar();
      check_value("tar_80", tar_val, 8'h80);
      bus = 8'h3C; wr = 1'b1; inc_tar = 1'b1; tick(); idle();
      check_value("tar_after_wr_inc", tar_val, 8'h81);
      load_ar(8'h80);
      #1 check_value("wr_inc_data", mem_out, 8'h3C);

      // ---------------- priority ----------------
      bus = 8'h10; ld_ar = 1'b1; inc_ar = 1'b1; tick(); idle();
      check_value("ar_priority", ar_val, 8'h10);
      ld_tar = 1'b1; inc_tar = 1'b1; tick(); idle();

      // ---------------- wrap ----------------
      load_ar(8'hFF);
      inc_ar = 1'b1; tick(); idle();
      check_value("ar_wrap", ar_val, 8'h00);
      load_ar(8'h04);
      load_tar_from_ar();
      inc_tar = 1'b1; tick(); idle();
      check_value("tar_wrap", tar_val, 8'h00);

      // ---------------- protection ----------------
      load_ar(8'h06);
      load_tar_from_ar();
      check_value("tar_10", tar_val, 8'h10);
      old = m_mem[8'h10];
      bus = 8'hAA; wr = 1'b1; tick(); idle();
      load_ar(8'h10);
      #1 check_value("low_write", mem_out, PROT ? old : 8'hAA);
      check_value("fault_set", fault, PROT);
      for (int i = 0; i < 256 && m_tar != 8'h40; i++) begin
         inc_tar = 1'b1; tick();
      end
      idle();
      bus = 8'h5A; wr = 1'b1; tick(); idle();
      load_ar(8'h40);
      #1 check_value("base_write", mem_out, 8'h5A);
      check_value("fault_sticky", fault, PROT);

      // ---------------- randomized run ----------------
      for (int i = 0; i < 400; i++) begin
         rand_strobes();
         h_valid = 1'($urandom); h_addr = 8'($urandom);
         h_data = 8'($urandom); h_last = 1'($urandom);
         tick();
      end
      idle();

      // ---------------- reset mid-run ----------------
      rst = 1'b1;
      m_reset();
      #1;
      $display("reset asserted mid-run");
      check_value("rst_run_enable", run_en, 1'b0);
      check_value("rst_host_ready", h_ready, 1'b0);
      check_value("rst_ar", ar_val, 8'h00);
      check_value("rst_tar", tar_val, 8'h00);
      check_value("rst_fault", fault, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      host_beat(8'h20, 8'($urandom), 1'b0);
      host_beat(8'h21, 8'($urandom), 1'b1);
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom);
         load_ar(a);
         #1 check_value("readback", mem_out, m_mem[a]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Unified program/data memory and address-register block: the responder side of the control unit's memory interface.
- Holds the fetch address register (AR) and the temp/data address register (TEMP_AR), serves combinational reads, and performs synchronous run-time writes.
- Provides a host program-load port with a valid/ready handshake. Run_enable gates the control unit out of its idle state.

Parameters:
DATA_W, 8, memory word and bus width
ADDR_W, 8, address width; depth = 2**ADDR_W
PROTECT_BASE, 8'h40, lowest writable run-time address (used only with MEM_WRITE_PROTECT_EN)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
BUS_1  in  DATA_W  datapath bus 1; source for address loads and write data
Load_ADDRESS_R  in  1  AR <= BUS_1
Load_TEMP_ADD_R  in  1  TEMP_AR <= Mem_out
INC_AR  in  1  AR <= AR+1
INC_TEMP_AR  in  1  TEMP_AR <= TEMP_AR+1
Select_MEMORY_DEMUX  in  1  0: read at AR; 1: read at TEMP_AR
Write_MEMORY  in  1  mem[TEMP_AR] <= BUS_1
Host_valid  in  1  host load beat valid
Host_addr  in  ADDR_W  host load address
Host_data  in  DATA_W  host load data
Host_last  in  1  final beat of program image
Host_ready  out  1  responder accepts a host beat
Run_enable  out  1  program loaded; control unit may run
Mem_out  out  DATA_W  read data to BUS_2 mux
AR_value  out  ADDR_W  current AR (debug)
TEMP_AR_value  out  ADDR_W  current TEMP_AR (debug)
Protect_fault  out  1  sticky illegal-write flag (feature only; otherwise tied 0)

Behaviour:
- Reset (async, RESET=1): AR=0, TEMP_AR=0, state=S_LOAD, Host_ready=0, Run_enable=0, Protect_fault=0. Memory contents are not cleared.
- Host_ready is registered. It goes to 1 on the first clock after RESET deasserts, provided state=S_LOAD.
- FSM states:
  - S_LOAD: Host_ready=1. A beat is accepted on a clock edge where Host_valid && Host_ready; the edge writes mem[Host_addr] <= Host_data. An accepted beat with Host_last=1 moves to S_RUN.
  - S_RUN: Host_ready=0, Run_enable=1. Host inputs are ignored. Stays in S_RUN until RESET.
- In S_LOAD, all control-unit strobes (Load_*, INC_*, Write_MEMORY) are ignored.
- Read path: Mem_out = mem[Select_MEMORY_DEMUX ? TEMP_AR : AR], combinational from the registered addresses.
  - Consequence: an AR load on edge N makes data valid in the cycle after edge N (fetch_1 -> fetch_2 timing).
- Load_TEMP_ADD_R takes Mem_out as sampled before the edge, i.e. the read at AR or TEMP_AR per the current demux select.
- AR update priority: Load_ADDRESS_R > INC_AR > hold.
- TEMP_AR update priority: Load_TEMP_ADD_R > INC_TEMP_AR > hold.
- Increments wrap modulo 2**ADDR_W (8'hFF+1 -> 8'h00). Nothing is flagged on wrap.
- Write_MEMORY is synchronous and uses TEMP_AR before any same-edge update. Write_MEMORY together with INC_TEMP_AR on the same edge writes the old address, then increments.
- Read-during-write to the same address: Mem_out shows old data until the edge, new data after it.
- RESET asserted mid-load or mid-run aborts immediately and returns to S_LOAD. A partial program image stays in memory.

Optional Feature:
- Macro: MEM_WRITE_PROTECT_EN.
- Defined:
  - A run-time Write_MEMORY with TEMP_AR < PROTECT_BASE is suppressed: memory is unchanged.
  - Such a write sets Protect_fault=1 on that edge; the flag stays set until RESET.
  - INC_TEMP_AR on the same edge still takes effect.
  - Host loads are never protected.
- Undefined: all writes are honoured and Protect_fault is tied 0.

Test Plan:
- Load handshake: reset, then host beats (00,8'h00),(01,8'h05),(02,8'h09 last) -> Host_ready=1 from the first post-reset clock; Run_enable=1 the cycle after the last beat; Host_ready=0 thereafter.
- Fetch read: in S_RUN, BUS_1=8'h01 with Load_ADDRESS_R -> next cycle Mem_out=8'h05 (demux=0). Then INC_AR -> Mem_out=8'h09.
- Indirect address: AR=8'h01, Load_TEMP_ADD_R -> TEMP_AR=8'h05. Then demux=1 -> Mem_out=mem[8'h05].
- Write+increment: TEMP_AR=8'h80, BUS_1=8'h3C, Write_MEMORY and INC_TEMP_AR together -> mem[8'h80]=8'h3C, TEMP_AR=8'h81. Priority check: Load_ADDRESS_R and INC_AR together with BUS_1=8'h10 -> AR=8'h10.
- Wrap and reset: AR=8'hFF, INC_AR -> AR=8'h00. Assert RESET mid-run -> Run_enable=0 and state=S_LOAD immediately; memory contents are retained on reload read-back.
- Protection (MEM_WRITE_PROTECT_EN): TEMP_AR=8'h10, Write_MEMORY with BUS_1=8'hAA -> mem[8'h10] unchanged, Protect_fault=1 and sticky. A write at 8'h40 succeeds.
